// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, TX FSM state encoding and the STATUS word packer.
package uart_tx_periph_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] status_word(input logic       busy,
                                              input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [3:0] count);
    logic [31:0] s;
    s                      = '0;
    s[STAT_BUSY]           = busy;
    s[STAT_FULL]           = full;
    s[STAT_EMPTY]          = empty;
    s[STAT_OVF]            = ovf;
    s[STAT_CNT_LSB +: 4]   = count;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_periph_if.sv
// Core data-bus slice seen by the UART peripheral: store traffic in,
// window select and combinational load data out.
interface uart_tx_periph_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        periph_sel;
  logic [31:0] periph_rdata;

  modport master (output mem_addr, mem_wdata, mem_we,
                  input  periph_sel, periph_rdata);
  modport slave  (input  mem_addr, mem_wdata, mem_we,
                  output periph_sel, periph_rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for TX bytes. dout is the head (valid while not empty);
// full is the pre-pop status, so the caller decides whether push-when-full is legal.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by count and the
  // pointers, so stale contents are never observable and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: address decode, TXDATA/STATUS/CTRL
// registers, TX FIFO and the serialising FSM.
module uart_tx_periph
  import uart_tx_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_periph_if.slave  bus,
  output logic             txd
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       reg_off;
  logic             push_req, push, pop, drop;
  logic             wr_status, wr_ctrl;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [CW-1:0]    fifo_count;
  logic             enable, overflow;
  tx_state_e        state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_done;
  logic             unused_bits;

  assign bus.periph_sel = (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_off        = bus.mem_addr[3:2];
  assign unused_bits    = ^{bus.mem_addr[1:0], bus.mem_wdata[31:8]};

  assign wr_status = bus.mem_we && bus.periph_sel && (reg_off == OFF_STATUS);
  assign wr_ctrl   = bus.mem_we && bus.periph_sel && (reg_off == OFF_CTRL);
  assign push_req  = bus.mem_we && bus.periph_sel && (reg_off == OFF_TXDATA);

  assign bit_done = (bit_cnt == '0);
  assign pop      = enable && !fifo_empty &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (bus.mem_wdata[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A dropped push wins over a same-cycle overflow clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) enable <= bus.mem_wdata[0];
      if (drop)                                    overflow <= 1'b1;
      else if (wr_status && bus.mem_wdata[STAT_OVF]) overflow <= 1'b0;
    end
  end

  // NOTE: all FSM state, including txd, uses non-blocking assignments so every
  // branch reads the pre-edge values of shift/bit_cnt regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state   <= ST_START;
            shift   <= fifo_dout;
            bit_cnt <= BIT_LAST;
            txd     <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done) begin
            state   <= ST_DATA;
            bit_cnt <= BIT_LAST;
            bit_idx <= '0;
            txd     <= shift[0];
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            bit_cnt <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              txd   <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              txd     <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            // Chain straight into the next start bit so frames stay contiguous.
            if (pop) begin
              state   <= ST_START;
              shift   <= fifo_dout;
              bit_cnt <= BIT_LAST;
              txd     <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: rdata gets a full default before the case so no path leaves it unassigned
  // (which would otherwise infer a latch).
  always_comb begin
    bus.periph_rdata = '0;
    if (bus.periph_sel) begin
      case (reg_off)
        OFF_STATUS: bus.periph_rdata = status_word(state != ST_IDLE, fifo_full, fifo_empty,
                                                   overflow, 4'(fifo_count));
        OFF_CTRL:   bus.periph_rdata[0] = enable;
        default:    bus.periph_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: directed scenarios plus random bus
// traffic, checked every cycle against a queue-and-frame-timer reference model.
module tb_uart_tx_periph;

  localparam int          CPB     = 16;
  localparam int          DEPTH   = 4;
  localparam int          FRAME   = 10 * CPB;
  localparam logic [31:0] BASE    = 32'h0000_2000;
  localparam logic [27:0] BASE_HI = BASE[31:4];

  logic clk = 1'b0;
  logic reset;
  logic txd;

  uart_tx_periph_if bus ();

  uart_tx_periph #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, the frame in flight as a countdown of
  // remaining line cycles plus the byte being sent.
  logic [7:0] m_q[$];
  int         m_left;
  logic [7:0] m_cur;
  bit         m_en;
  bit         m_ovf;

  function automatic logic m_txd();
    int pos, b;
    if (m_left == 0) return 1'b1;
    pos = FRAME - m_left;
    b   = pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] addr);
    int n;
    if (addr[31:4] != BASE_HI) return 32'h0;
    n = m_q.size();
    case (addr[3:2])
      2'd1:    return {24'h0, 4'(n), m_ovf, n == 0, n == DEPTH, m_left > 0};
      2'd2:    return {31'h0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit rst);
    bit hit, pop, push_req, full;
    if (rst) begin
      m_q.delete();
      m_left = 0;
      m_cur  = 8'h00;
      m_en   = 1'b1;
      m_ovf  = 1'b0;
      return;
    end
    hit      = (addr[31:4] == BASE_HI);
    pop      = m_en && (m_q.size() > 0) && (m_left <= 1);
    push_req = we && hit && (addr[3:2] == 2'd0);
    full     = (m_q.size() == DEPTH);
    if (pop) begin
      m_cur  = m_q.pop_front();
      m_left = FRAME;
    end else if (m_left > 0) begin
      m_left--;
    end
    if (push_req && (!full || pop)) m_q.push_back(wdata[7:0]);
    if (push_req && full && !pop)                      m_ovf = 1'b1;
    else if (we && hit && addr[3:2] == 2'd1 && wdata[3]) m_ovf = 1'b0;
    if (we && hit && addr[3:2] == 2'd2) m_en = wdata[0];
  endtask

  // One bus cycle: drive at the falling edge, check combinational outputs,
  // advance model on the rising edge, check txd at the next falling edge.
  task automatic step(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit rst = 1'b0);
    bus.mem_we    = we;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    reset         = rst;
    #1;
    check("sel", {31'h0, bus.periph_sel}, {31'h0, addr[31:4] == BASE_HI});
    check("rdata", bus.periph_rdata, m_rdata(addr));
    @(posedge clk);
    model_step(we, addr, wdata, rst);
    @(negedge clk);
    check("txd", {31'h0, txd}, {31'h0, m_txd()});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, BASE + 32'h4, 32'h0);
  endtask

  logic [7:0]  rx;
  logic [31:0] addr_r;
  int          r;
  int          guard;

  initial begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    reset         = 1'b1;
    @(negedge clk);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    check("rst_txd", {31'h0, txd}, 32'h1);
    step(1'b0, BASE + 32'h4, 32'h0);
    check("rst_status", bus.periph_rdata, 32'h4);
    step(1'b0, BASE + 32'h8, 32'h0);
    check("rst_ctrl", bus.periph_rdata, 32'h1);

    // Single byte 0x55: start bit at E+1, LSB-first data, busy clears after 160 cycles.
    step(1'b1, BASE, 32'h55);
    step(1'b0, BASE + 32'h4, 32'h0);
    check("tx55_start", {31'h0, txd}, 32'h0);
    rx = 8'h00;
    for (int i = 1; i < FRAME; i++) begin
      step(1'b0, BASE + 32'h4, 32'h0);
      if ((i % CPB) == 8 && i / CPB >= 1 && i / CPB <= 8) rx[i/CPB - 1] = txd;
    end
    check("tx55_byte", {24'h0, rx}, 32'h55);
    check("tx55_busy_end", {31'h0, bus.periph_rdata[0]}, 32'h1);
    step(1'b0, BASE + 32'h4, 32'h0);
    check("tx55_idle", {31'h0, bus.periph_rdata[0]}, 32'h0);

    // Three back-to-back stores: contiguous frames, count 2 -> 1 -> 0.
    step(1'b1, BASE, 32'h41);
    step(1'b1, BASE, 32'h42);
    step(1'b1, BASE, 32'h43);
    step(1'b0, BASE + 32'h4, 32'h0);
    check("bb_cnt2", {28'h0, bus.periph_rdata[7:4]}, 32'h2);
    run(158);
    check("bb_cnt1", {28'h0, bus.periph_rdata[7:4]}, 32'h1);
    run(160);
    check("bb_cnt0", {28'h0, bus.periph_rdata[7:4]}, 32'h0);
    run(159);
    check("bb_busy_last", {31'h0, bus.periph_rdata[0]}, 32'h1);
    run(1);
    check("bb_busy_done", {31'h0, bus.periph_rdata[0]}, 32'h0);

    // Disabled: six stores fill the FIFO and set overflow; clear; enable sends four.
    step(1'b1, BASE + 32'h8, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, BASE, 32'($urandom_range(0, 255)));
      if (i == 3) begin
        step(1'b0, BASE + 32'h4, 32'h0);
        check("ovf_full4", bus.periph_rdata, 32'h42);
      end
      if (i == 4) begin
        step(1'b0, BASE + 32'h4, 32'h0);
        check("ovf_set5", {31'h0, bus.periph_rdata[3]}, 32'h1);
      end
    end
    step(1'b1, BASE + 32'h4, 32'h8);
    check("ovf_clear", bus.periph_rdata, 32'h42);
    step(1'b1, BASE + 32'h8, 32'h1);
    run(4 * FRAME + 10);
    check("ovf_drained", bus.periph_rdata, 32'h4);

    // Full FIFO with a push landing on the STOP->START pop.
    step(1'b1, BASE + 32'h8, 32'h0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, BASE, 32'($urandom_range(0, 255)));
    step(1'b1, BASE + 32'h8, 32'h1);
    step(1'b1, BASE, 32'hA5);
    guard = 0;
    while (m_left != 1 && guard < 2 * FRAME) begin
      step(1'b0, BASE + 32'h4, 32'h0);
      guard++;
    end
    check("fullpop_reach_stop", {31'h0, m_left == 1}, 32'h1);
    step(1'b1, BASE, 32'h3C);
    step(1'b0, BASE + 32'h4, 32'h0);
    check("fullpop_cnt", {28'h0, bus.periph_rdata[7:4]}, 32'h4);
    check("fullpop_ovf", {31'h0, bus.periph_rdata[3]}, 32'h0);
    run(5 * FRAME + 10);

    // Reset 50 cycles into a frame: line returns high and the queue is discarded.
    for (int i = 0; i < 3; i++) step(1'b1, BASE, 32'($urandom_range(0, 255)));
    run(48);
    step(1'b0, BASE + 32'h4, 32'h0, 1'b1);
    check("midrst_txd", {31'h0, txd}, 32'h1);
    check("midrst_status", bus.periph_rdata, 32'h4);
    run(3 * FRAME);
    check("midrst_quiet", bus.periph_rdata, 32'h4);

    // Reserved offset and out-of-window accesses.
    step(1'b0, BASE + 32'hC, 32'h0);
    check("rsvd_sel", {31'h0, bus.periph_sel}, 32'h1);
    check("rsvd_rdata", bus.periph_rdata, 32'h0);
    step(1'b1, BASE + 32'hC, 32'hFFFF_FFFF);
    step(1'b0, 32'h0000_3000, 32'h0);
    check("oow_sel", {31'h0, bus.periph_sel}, 32'h0);
    check("oow_rdata", bus.periph_rdata, 32'h0);
    step(1'b1, 32'h0000_3000, 32'hAA);
    step(1'b0, BASE + 32'h4, 32'h0);
    check("oow_no_push", bus.periph_rdata, 32'h4);

    // Random traffic.
    for (int i = 0; i < 12000; i++) begin
      r = $urandom_range(0, 99);
      addr_r = BASE | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 1999) == 0)
        step(1'b0, addr_r, 32'h0, 1'b1);
      else if (r < 6)
        step(1'b1, BASE | 32'($urandom_range(0, 3)), $urandom);
      else if (r < 8)
        step(1'b1, BASE + 32'h4, $urandom);
      else if (r < 9)
        step(1'b1, BASE + 32'h8, {31'h0, $urandom_range(0, 3) != 0});
      else if (r < 11)
        step(1'b1, BASE ^ (32'h1 << $urandom_range(4, 31)), $urandom);
      else if (r < 12)
        step(1'b1, BASE + 32'hC, $urandom);
      else
        step(1'b0, addr_r, 32'h0);
    end
    step(1'b1, BASE + 32'h8, 32'h1);
    run(DEPTH * FRAME + FRAME + 10);
    check("final_idle", bus.periph_rdata, {24'h0, 4'h0, m_ovf, 3'b100});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_periph.md
# uart_tx_periph

Memory-mapped UART transmitter on the `riscv_soc` data bus, in parallel with `memory`. It consumes the core's store traffic (`mem_addr`/`mem_wdata`/`mem_we`) in its address window and buffers bytes in a small FIFO. It serialises each byte as an 8N1 frame on `txd` and returns status on loads. The SoC muxes `periph_rdata` onto `mem_rdata` whenever `periph_sel` is high.

## Interface
- `BASE_ADDR`, default 32'h0000_2000: word-aligned base of the 16-byte register window.
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, default 4: TX FIFO entries; must be a power of 2, ≥ 2.

Ports:
- `clk`, input, 1: system clock. One clock domain; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `mem_addr`, input, 32: core data address.
- `mem_wdata`, input, 32: core store data.
- `mem_we`, input, 1: store strobe. Each high cycle is one write.
- `periph_sel`, output, 1: combinational; high when `mem_addr[31:4] == BASE_ADDR[31:4]`.
- `periph_rdata`, output, 32: combinational register read data. It is 0 when `periph_sel` is low.
- `txd`, output, 1: serial line; idles high.

## Operation
Register map (offset, with `mem_addr[1:0]` ignored):
- `0x0 TXDATA`, write-only: push `mem_wdata[7:0]` into the FIFO. Reads return 0.
- `0x4 STATUS`: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count. All other bits read 0. Writing with `mem_wdata[3]=1` clears overflow; all other write bits are ignored.
- `0x8 CTRL`: bit0 `enable`, read/write.
- `0xC`: reserved. Reads return 0; writes are ignored.

FIFO rules:
- A push is one cycle with `mem_we`, a window hit and offset `0x0`.
- A push into a full FIFO is dropped and sets overflow. The exception is a same-cycle pop, in which case the push is accepted.
- Pop and push in the same cycle leave the count unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.

FSM states:
- `IDLE`: `txd`=1. Moves to `START` if `enable` and FIFO not empty; the FIFO head is popped into the shift register on that edge.
- `START`: `txd`=0 for `CLKS_PER_BIT` cycles, then `DATA`.
- `DATA`: `txd`=shift[0], LSB first. The register shifts every `CLKS_PER_BIT` cycles; after 8 bits the FSM moves to `STOP`.
- `STOP`: `txd`=1 for `CLKS_PER_BIT` cycles. Then, if `enable` and FIFO not empty, pop and go straight to `START` (no idle gap); otherwise go to `IDLE`.

Other rules:
- The bit counter is a `$clog2(CLKS_PER_BIT)`-bit down-counter; the bit index is a 3-bit counter.
- Clearing `enable` mid-frame finishes the current frame and then holds in `IDLE`.

## Timing
- Reset values: `txd`=1, state `IDLE`, FIFO empty (count 0), overflow 0, `enable`=1, shift register 0.
- `periph_sel` and `periph_rdata` are combinational, with zero load latency, matching `memory`.
- A write captured at edge E puts the entry in the FIFO after E. The FSM pops at E+1, so `txd` is low from E+1.
- Frame length is exactly `10*CLKS_PER_BIT` cycles. Back-to-back frames are contiguous.
- STATUS reflects register state after the preceding edge. A push at edge E is visible in count from E onward.
- Reset asserted mid-frame: on the next edge all state returns to reset values, `txd` goes to 1 immediately, and queued bytes are discarded.
- A write to CTRL or the overflow clear takes effect on the same edge as the store. An overflow clear and a dropped push in the same cycle leave overflow set.

## Structure
- Shared header `uart_defs.vh`: register offsets, STATUS bit positions, FSM state encoding (2-bit localparams).
- Sub-module `uart_tx_fifo`: synchronous FIFO (parameters `WIDTH`=8, `DEPTH`). Ports: `clk`, `reset`, `push`, `din`, `pop`, `dout`, `full`, `empty`, `count`. `dout` is the head, valid while not empty; `full` is the pre-pop status. The top level implements the push-with-pop-when-full rule.
- The top level holds the decode, registers and TX FSM.

## Test plan
- Reset, then store 0x55 to `0x2000` at edge E: `txd` is low at E+1, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high; busy returns to 0 after 160 cycles.
- Store 0x41, 0x42, 0x43 on consecutive cycles: three contiguous frames in 480 cycles with no idle gap; STATUS count reads 2, 1, 0 as each byte pops.
- Store 6 bytes back-to-back while `enable`=0: count=4 and full=1; overflow=1 after the 5th store. Writing 0x8 to `0x2004` clears overflow. Setting `enable`=1 sends exactly 4 frames.
- FIFO full, with a push coinciding with the STOP→START pop: the push is accepted, count stays 4, overflow stays 0.
- Assert `reset` at cycle 50 of a frame: `txd`=1 on the next edge, STATUS reads 0x04, and the queued bytes are never sent.
- Loads from `0x200C` and from `0x3000`: rdata is 0, and `periph_sel` is 1 and 0 respectively.
